// File: rtl/polar_bp_decoder_iter.sv
// Iterative min-sum belief-propagation decoder for polar codes, N = 2^N_LOG.
// One butterfly stage is processed per cycle: N_LOG left-sweep cycles, then
// N_LOG right-sweep cycles, then one decision/early-stop check cycle.
module polar_bp_decoder_iter #(
  parameter int N_LOG = 3,
  parameter int W     = 8,
  parameter int ITW   = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1<<N_LOG)*W-1:0]     in_llr,
  input  logic [(1<<N_LOG)-1:0]       in_frozen,
  input  logic [ITW-1:0]              in_max_iter,
  input  logic                        in_es_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(1<<N_LOG)-1:0]       out_bits,
  output logic [ITW-1:0]              out_iters,
  output logic                        out_conv,
  output logic                        busy
);

  localparam int N  = 1 << N_LOG;
  localparam int IW = N_LOG;
  localparam int CW = $clog2(N_LOG + 1);

  typedef logic signed [W-1:0] llr_t;

  localparam llr_t MAXV   = {1'b0, {(W-1){1'b1}}};
  localparam llr_t MINV   = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam llr_t NEGMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] S_TOP = CW'(N_LOG - 1);

  typedef enum logic [2:0] {IDLE, LSWEEP, RSWEEP, CHECK, OUTS} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   stage, stage_p1;
  logic [ITW-1:0]  iter, max_q;
  logic [N-1:0]    fr_q;
  logic            es_q;
  llr_t            lm [N_LOG+1][N];
  llr_t            rm [N_LOG+1][N];
  llr_t            l_nxt [N];
  llr_t            r_nxt [N];
  logic [N-1:0]    u_hat, x_hat;
  logic            conv, done;

  // Saturating add; result is always kept within +/-MAXV.
  function automatic llr_t sadd(input llr_t a, input llr_t b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? MINV : MAXV;
    if (s[W-1:0] == NEGMIN) return MINV;
    return s[W-1:0];
  endfunction

  // Min-sum check-node kernel; a zero operand counts as positive.
  function automatic llr_t fmin(input llr_t a, input llr_t b);
    logic [W-1:0] ma, mb, m;
    ma = a[W-1] ? -a : a;
    mb = b[W-1] ? -b : b;
    m  = (ma < mb) ? ma : mb;
    return (a[W-1] ^ b[W-1]) ? -m : m;
  endfunction

  function automatic logic neg_sum(input llr_t a, input llr_t b);
    llr_t t;
    t = sadd(a, b);
    return t[W-1];
  endfunction

  // XOR butterfly x = u * F^{(x)N_LOG}, natural order.
  function automatic logic [N-1:0] polar_encode(input logic [N-1:0] u);
    logic [N-1:0] v;
    v = u;
    for (int unsigned s = 0; s < N_LOG; s++)
      for (int unsigned j = 0; j < N; j++)
        if (((j >> s) & 32'd1) == 32'd0)
          v[IW'(j)] = v[IW'(j)] ^ v[IW'(j + (32'd1 << s))];
    return v;
  endfunction

  assign stage_p1 = stage + CW'(1);

  // Butterfly outputs for the current stage; both sweeps read L[s+1] and R[s].
  always_comb begin : sweep_comb
    logic [IW-1:0] jj, kk;
    jj = '0;
    kk = '0;
    for (int unsigned j = 0; j < N; j++) begin
      l_nxt[IW'(j)] = '0;
      r_nxt[IW'(j)] = '0;
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (((j >> stage) & 32'd1) == 32'd0) begin
        jj = IW'(j);
        kk = IW'(j + (32'd1 << stage));
        l_nxt[jj] = fmin(lm[stage_p1][jj], sadd(lm[stage_p1][kk], rm[stage][kk]));
        l_nxt[kk] = sadd(fmin(rm[stage][jj], lm[stage_p1][jj]), lm[stage_p1][kk]);
        r_nxt[jj] = fmin(rm[stage][jj], sadd(lm[stage_p1][kk], rm[stage][kk]));
        r_nxt[kk] = sadd(fmin(rm[stage][jj], lm[stage_p1][jj]), rm[stage][kk]);
      end
    end
  end

  // Hard decisions at both ends of the graph and the termination decision.
  always_comb begin
    u_hat = '0;
    x_hat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      u_hat[IW'(i)] = neg_sum(lm[CW'(0)][IW'(i)], rm[CW'(0)][IW'(i)]) & ~fr_q[IW'(i)];
      x_hat[IW'(i)] = neg_sum(lm[CW'(N_LOG)][IW'(i)], rm[CW'(N_LOG)][IW'(i)]);
    end
    conv = es_q & (polar_encode(u_hat) == x_hat);
    done = conv | (iter == max_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = LSWEEP;
      LSWEEP:  if (stage == '0)       state_nxt = RSWEEP;
      RSWEEP:  if (stage == S_TOP)    state_nxt = CHECK;
      CHECK:   state_nxt = done ? OUTS : LSWEEP;
      OUTS:    if (out_ready)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake / status outputs.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUTS);
    busy      = (state != IDLE);
  end

  // Message memories, stage/iteration counters and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c <= N_LOG; c++)
        for (int unsigned i = 0; i < N; i++) begin
          lm[CW'(c)][IW'(i)] <= '0;
          rm[CW'(c)][IW'(i)] <= '0;
        end
      stage     <= '0;
      iter      <= '0;
      max_q     <= '0;
      fr_q      <= '0;
      es_q      <= 1'b0;
      out_bits  <= '0;
      out_iters <= '0;
      out_conv  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int unsigned c = 0; c <= N_LOG; c++)
            for (int unsigned i = 0; i < N; i++) begin
              if (c == N_LOG)
                lm[CW'(c)][IW'(i)] <= (in_llr[i*W +: W] == NEGMIN) ? MINV : llr_t'(in_llr[i*W +: W]);
              else
                lm[CW'(c)][IW'(i)] <= '0;
              if (c == 0)
                rm[CW'(c)][IW'(i)] <= in_frozen[IW'(i)] ? MAXV : '0;
              else
                rm[CW'(c)][IW'(i)] <= '0;
            end
          fr_q  <= in_frozen;
          es_q  <= in_es_en;
          max_q <= (in_max_iter == '0) ? ITW'(1) : in_max_iter;
          iter  <= ITW'(1);
          stage <= S_TOP;
        end
        LSWEEP: begin
          for (int unsigned i = 0; i < N; i++) lm[stage][IW'(i)] <= l_nxt[IW'(i)];
          if (stage != '0) stage <= stage - CW'(1);
        end
        RSWEEP: begin
          for (int unsigned i = 0; i < N; i++) rm[stage_p1][IW'(i)] <= r_nxt[IW'(i)];
          if (stage != S_TOP) stage <= stage + CW'(1);
        end
        CHECK: begin
          if (done) begin
            out_bits  <= u_hat;
            out_iters <= iter;
            out_conv  <= conv;
          end else begin
            iter  <= iter + ITW'(1);
            stage <= S_TOP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_bp_decoder_iter.sv
// Directed bench for polar_bp_decoder_iter (N_LOG=3, W=8, ITW=5) with a
// queue-based scoreboard of expected results.
module tb_polar_bp_decoder_iter;

  localparam int N_LOG = 3;
  localparam int W     = 8;
  localparam int ITW   = 5;
  localparam int N     = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_llr;
  logic [N-1:0]     in_frozen;
  logic [ITW-1:0]   in_max_iter;
  logic             in_es_en;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_bits;
  logic [ITW-1:0]   out_iters;
  logic             out_conv;
  logic             busy;

  typedef struct {
    string      tag;
    logic [7:0] bits;
    logic [4:0] iters;
    logic       conv;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  polar_bp_decoder_iter #(.N_LOG(N_LOG), .W(W), .ITW(ITW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_llr     (in_llr),
    .in_frozen  (in_frozen),
    .in_max_iter(in_max_iter),
    .in_es_en   (in_es_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_iters  (out_iters),
    .out_conv   (out_conv),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // x_j = XOR of u_i over all i whose bit set contains j.
  function automatic logic [7:0] enc_ref(input logic [7:0] u);
    logic [7:0] x;
    x = '0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if (((i & j) == j) && u[3'(i)]) x[3'(j)] = ~x[3'(j)];
    return x;
  endfunction

  function automatic logic [63:0] llr_of(input logic [7:0] x, input logic [7:0] mag);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = x[3'(i)] ? -mag : mag;
    return v;
  endfunction

  task automatic drive_block(input logic [63:0] llr, input logic [7:0] fr,
                             input logic [4:0] mi, input logic es);
    @(negedge clk);
    in_llr      = llr;
    in_frozen   = fr;
    in_max_iter = mi;
    in_es_en    = es;
    in_valid    = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_llr      = {$urandom(), $urandom()};
    in_frozen   = 8'($urandom());
    in_max_iter = 5'($urandom());
    in_es_en    = 1'($urandom());
  endtask

  task automatic collect();
    exp_t e;
    int   cyc;
    e   = sb.pop_front();
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({e.tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({e.tag, "_latency"},   cyc, e.lat);
    check({e.tag, "_bits"},      32'(out_bits), 32'(e.bits));
    check({e.tag, "_iters"},     32'(out_iters), 32'(e.iters));
    check({e.tag, "_conv"},      32'(out_conv), 32'(e.conv));
    check({e.tag, "_in_ready"},  32'(in_ready), 32'd0);
  endtask

  task automatic finish_out(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_idle_in_ready"},  32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_busy"},      32'(busy), 32'd0);
  endtask

  initial begin
    logic [63:0] all100;
    logic [63:0] llr3;
    exp_t        e;

    all100 = llr_of(8'h00, 8'd100);
    llr3   = all100;
    llr3[3*8 +: 8] = 8'hEC;

    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_llr      = '0;
    in_frozen   = '0;
    in_max_iter = '0;
    in_es_en    = 1'b0;
    out_ready   = 1'b1;
    #3 rst_n = 1'b0;
    #14;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_bits",  32'(out_bits),  32'd0);
    check("rst_out_iters", 32'(out_iters), 32'd0);
    check("rst_out_conv",  32'(out_conv),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero codeword, early stop on first check.
    e = '{tag: "t1_es", bits: 8'h00, iters: 5'd1, conv: 1'b1, lat: 7};
    sb.push_back(e);
    drive_block(all100, 8'h17, 5'd8, 1'b1);
    collect();
    finish_out("t1");

    // Early stop disabled: full iteration count.
    e = '{tag: "t2_noes", bits: 8'h00, iters: 5'd5, conv: 1'b0, lat: 35};
    sb.push_back(e);
    drive_block(all100, 8'h17, 5'd5, 1'b0);
    collect();
    finish_out("t2");

    // max_iter = 0 behaves as one iteration.
    e = '{tag: "t_max0", bits: 8'h00, iters: 5'd1, conv: 1'b0, lat: 7};
    sb.push_back(e);
    drive_block(all100, 8'h17, 5'd0, 1'b0);
    collect();
    finish_out("tmax0");

    // One weak wrong-sign channel LLR, corrected in the first iteration.
    e = '{tag: "t3_err", bits: 8'h00, iters: 5'd1, conv: 1'b1, lat: 7};
    sb.push_back(e);
    drive_block(llr3, 8'h17, 5'd8, 1'b1);
    collect();
    finish_out("t3");

    // Nonzero codeword.
    e = '{tag: "t4_cw", bits: 8'hA8, iters: 5'd1, conv: 1'b1, lat: 7};
    sb.push_back(e);
    drive_block(llr_of(enc_ref(8'hA8), 8'd100), 8'h17, 5'd8, 1'b1);
    collect();
    finish_out("t4");

    // Output backpressure, then a back-to-back block.
    out_ready = 1'b0;
    e = '{tag: "t5_a", bits: 8'h00, iters: 5'd1, conv: 1'b1, lat: 7};
    sb.push_back(e);
    drive_block(all100, 8'h17, 5'd8, 1'b1);
    collect();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_bits",  32'(out_bits),  32'd0);
      check("t5_hold_iters", 32'(out_iters), 32'd1);
      check("t5_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    finish_out("t5a");
    e = '{tag: "t5_b", bits: 8'hA8, iters: 5'd1, conv: 1'b1, lat: 7};
    sb.push_back(e);
    drive_block(llr_of(enc_ref(8'hA8), 8'd100), 8'h17, 5'd8, 1'b1);
    collect();
    finish_out("t5b");

    // Reset in the middle of a left sweep aborts the block.
    drive_block(all100, 8'h17, 5'd8, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t6_busy_pre_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy",      32'(busy),      32'd0);
    check("t6_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_post_rst_valid", 32'(out_valid), 32'd0);

    // All -128: clamped to -127; all-ones channel word is the codeword u7 = 1.
    e = '{tag: "t6_neg", bits: 8'h80, iters: 5'd1, conv: 1'b0, lat: 7};
    sb.push_back(e);
    drive_block(64'h8080_8080_8080_8080, 8'h17, 5'd1, 1'b0);
    collect();
    finish_out("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
